// File: rtl/rom_pkg.sv
// Shared types and defaults for the ROM burst reader.
// Used by rom_reader and rom_reader_fifo.
package rom_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rom_rd_state_t;

  typedef struct packed {
    logic                 last;
    logic [WIDTH_DEF-1:0] data;
  } rom_entry_t;

endpackage

// File: rtl/rom_reader_fifo.sv
// Two-entry synchronous FIFO with occupancy count.
// Push and pop may coincide; order is preserved.
module rom_reader_fifo
  import rom_pkg::*;
#(
  parameter int W = WIDTH_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  assign dout = mem[rp];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO would lose a word.
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) begin
      assert (count != 2'd2);
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Burst address sequencer and valid/ready output stage for a ROM.
// Optional stall counter port enabled by ROM_READER_STATS_EN.
module rom_reader
  import rom_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
`ifdef ROM_READER_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  rom_rd_state_t state;
  rom_rd_state_t state_nx;

  logic [AW-1:0] cnt;
  logic [AW:0]   remaining;
  logic          inflight;
  logic          inflight_last;
  logic          zero_done;
  logic [1:0]    fifo_count;
  logic [2:0]    occ;
  logic          pop;
  logic          issue;
  logic          last_issue;
  logic          accept;
  logic          drained;

  assign pop       = out_valid & out_ready;
  // A word leaving this cycle frees its slot for the next capture.
  assign occ       = {1'b0, fifo_count} + {2'b0, inflight}
                   - {2'b0, pop};
  assign issue     = (state == RUN) && (remaining != '0)
                   && (occ < 3'd2);
  assign last_issue = issue && (remaining == (AW+1)'(1));
  assign accept    = (state == IDLE) && start && (len != '0);
  assign drained   = (fifo_count == 2'd0) && !inflight;

  assign busy      = (state != IDLE);
  assign done      = zero_done || ((state == DRAIN) && drained);
  assign out_valid = (fifo_count != 2'd0);

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, address counter and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      remaining     <= '0;
      rom_addr      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= issue;
      inflight_last <= last_issue;
      zero_done     <= (state == IDLE) && start && (len == '0);
      if (accept) begin
        cnt       <= start_addr;
        remaining <= len;
      end else if (issue) begin
        rom_addr  <= cnt;
        cnt       <= cnt + AW'(1);
        remaining <= remaining - (AW+1)'(1);
      end
    end
  end

  rom_reader_fifo #(
    .W (WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, rom_data}),
    .pop   (pop),
    .dout  ({out_last, out_data}),
    .count (fifo_count)
  );

`ifdef ROM_READER_STATS_EN
  // Saturating count of stalled cycles within a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready
                 && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader.
// Directed bursts with a queue-based word checker.
module tb_rom_reader;
  import rom_pkg::*;

  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
`ifdef ROM_READER_STATS_EN
  logic [15:0]   stall_cycles;
`endif

  rom_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef ROM_READER_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [D];
  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'(16'h1000 + i);
  end
  assign rom_data = mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         xfers = 0;
  int         t0;
  int         dcyc;
  rom_entry_t exp_q [$];
  bit         ready_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected word on every transfer; check stall hold.
  rom_entry_t e;
  logic       hold_v = 1'b0;
  logic [W-1:0] hold_d;
  logic       hold_l;
  always @(negedge clk) begin
    if (!rst && hold_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(hold_d));
      chk("hold_last", 32'(out_last), 32'(hold_l));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 32'(out_data), 32'(e.data));
        chk("word_last", 32'(out_last), 32'(e.last));
      end
      xfers++;
    end
    hold_v = !rst && out_valid && !out_ready;
    hold_d = out_data;
    hold_l = out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_q.size() != 0) out_ready = ready_q.pop_front();
    else out_ready = 1'b1;
  endtask

  task automatic do_start(input int addr, input int n, input bit exp);
    rom_entry_t x;
    start      = 1'b1;
    start_addr = AW'(addr);
    len        = (AW+1)'(n);
    tick();
    start = 1'b0;
    t0    = cyc;
    if (exp) begin
      for (int i = 0; i < n; i++) begin
        x.data = W'(16'h1000 + ((addr + i) % D));
        x.last = (i == n - 1);
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      dcyc = -1;
      $display("FAIL done_timeout: got none expected pulse");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tfirst;
    int xbase;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    tick();

    // Basic burst, full throughput.
    do_start(0, 10, 1'b1);
    chk("b1_busy", 32'(busy), 32'd1);
    chk("b1_valid_c0", 32'(out_valid), 32'd0);
    tick();
    chk("b1_valid_c1", 32'(out_valid), 32'd0);
    tick();
    chk("b1_valid_c2", 32'(out_valid), 32'd1);
    chk("b1_first", 32'(out_data), 32'h1000);
    wait_done(40);
    chk("b1_done_cyc", 32'(dcyc - t0), 32'd12);
    tick();
    chk("b1_done_pulse", 32'(done), 32'd0);
    chk("b1_idle", 32'(busy), 32'd0);
    chk("b1_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap.
    do_start(1020, 8, 1'b1);
    wait_done(40);
    chk("wrap_done_cyc", 32'(dcyc - t0), 32'd10);
    tick();
    chk("wrap_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure.
    ready_q = '{1, 1, 0, 0, 1, 0, 1, 1};
    do_start(40, 6, 1'b1);
    wait_done(40);
    chk("bp_done_cyc", 32'(dcyc - t0), 32'd11);
`ifdef ROM_READER_STATS_EN
    chk("bp_stalls", 32'(stall_cycles), 32'd3);
`endif
    tick();
    tick();
    chk("bp_empty", 32'(exp_q.size()), 32'd0);
`ifdef ROM_READER_STATS_EN
    chk("bp_stalls_hold", 32'(stall_cycles), 32'd3);
`endif

    // Zero-length burst.
    do_start(5, 0, 1'b1);
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_valid", 32'(out_valid), 32'd0);
    tick();
    chk("z_done_off", 32'(done), 32'd0);
    chk("z_valid2", 32'(out_valid), 32'd0);

    // Start while busy is ignored.
    do_start(200, 4, 1'b1);
    tfirst = t0;
    do_start(300, 4, 1'b0);
    wait_done(40);
    chk("sb_done_cyc", 32'(dcyc - tfirst), 32'd6);
    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_valid", 32'(out_valid), 32'd0);
    chk("sb_busy", 32'(busy), 32'd0);

    // Reset mid-burst.
    do_start(0, 16, 1'b1);
    xbase = xfers;
    for (int i = 0; i < 40 && (xfers - xbase) < 5; i++) tick();
    chk("mr_xfers", 32'((xfers - xbase) >= 5), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_addr", 32'(rom_addr), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_last", 32'(out_last), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_done", 32'(done), 32'd0);
    end
    do_start(100, 2, 1'b1);
    wait_done(20);
    chk("mr2_done_cyc", 32'(dcyc - t0), 32'd4);
    tick();
    chk("mr2_empty", 32'(exp_q.size()), 32'd0);

    // Full-depth burst with wrap.
    do_start(512, 1024, 1'b1);
    wait_done(1100);
    chk("full_done_cyc", 32'(dcyc - t0), 32'd1026);
    tick();
    chk("full_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
